// File: rtl/bitcnt_pkg.sv
// bitcnt_pkg: mode/state enums and result-width helper shared by the bit-counting unit
package bitcnt_pkg;
  typedef enum logic [1:0] {CLZ = 2'b00, CTZ = 2'b01, CPOP = 2'b10, LZMASK = 2'b11} mode_e;
  typedef enum logic [1:0] {IDLE = 2'b00, SCAN = 2'b01, DONE = 2'b10} state_e;
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/bitcnt_chunk.sv
// bitcnt_chunk: combinational per-chunk leading/trailing-zero count, popcount, zero flag and leading-zero submask
module bitcnt_chunk #(
  parameter int CHUNK = 8,
  localparam int CC = $clog2(CHUNK + 1)
) (
  input  logic [CHUNK-1:0] d_i,
  output logic [CC-1:0]    lz_o,
  output logic [CC-1:0]    tz_o,
  output logic [CC-1:0]    pop_o,
  output logic             zero_o,
  output logic [CHUNK-1:0] lzmask_o
);
  logic hi_zero, lo_zero;
  // Walk inward from each end; a zero run ends at the first set bit seen from that side.
  always_comb begin
    hi_zero = 1'b1;
    lo_zero = 1'b1;
    lz_o = '0;
    tz_o = '0;
    pop_o = '0;
    lzmask_o = '0;
    for (int i = CHUNK - 1; i >= 0; i--) begin
      hi_zero = hi_zero & ~d_i[i];
      lzmask_o[i] = hi_zero;
      lz_o = lz_o + CC'(hi_zero);
      pop_o = pop_o + CC'(d_i[i]);
    end
    for (int i = 0; i < CHUNK; i++) begin
      lo_zero = lo_zero & ~d_i[i];
      tz_o = tz_o + CC'(lo_zero);
    end
    zero_o = hi_zero;
  end
endmodule

// File: rtl/bitcnt_seq.sv
// bitcnt_seq: iterative CLZ/CTZ/CPOP/LZMASK unit, CHUNK bits per cycle; BITCNT_EARLYOUT_EN ends CLZ/CTZ/LZMASK scans at the first set chunk
module bitcnt_seq
  import bitcnt_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CHUNK = 8,
  localparam int CW = cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ReqValid,
  output logic             ReqReady,
  input  logic [1:0]       Mode,
  input  logic             W,
  input  logic [WIDTH-1:0] A,
  input  logic             Flush,
  output logic             ResValid,
  input  logic             ResReady,
  output logic [CW-1:0]    Count,
  output logic [WIDTH-1:0] Mask
);
  localparam int CC = $clog2(CHUNK + 1);
  localparam int NF = WIDTH / CHUNK;
  localparam int IW = $clog2(NF);
  localparam int HW = WIDTH / 2;

  state_e state_q, state_d;
  mode_e mode_q;
  logic w_q, found_q, msb, ld_msb, zero, last, early, fin, accept;
  logic [IW-1:0] idx_q;
  logic [WIDTH-1:0] op_q, op_ld, macc_q, macc_d, mask_q;
  logic [CW-1:0] acc_q, acc_d, count_q, add, sh;
  logic [CHUNK-1:0] chunk, lzm;
  logic [CC-1:0] lz, tz, pop;

  bitcnt_chunk #(.CHUNK(CHUNK)) u_chunk (
    .d_i(chunk), .lz_o(lz), .tz_o(tz), .pop_o(pop), .zero_o(zero), .lzmask_o(lzm)
  );

`ifdef BITCNT_EARLYOUT_EN
  assign early = (mode_q != CPOP) && !zero;
`else
  assign early = 1'b0;
`endif

  // The operand is pre-aligned so the current chunk always sits at the top (MSB-first) or bottom (LSB-first).
  always_comb begin
    msb = (mode_q == CLZ) || (mode_q == LZMASK);
    ld_msb = (Mode == CLZ) || (Mode == LZMASK);
    op_ld = W ? (ld_msb ? {A[HW-1:0], {HW{1'b0}}} : {{HW{1'b0}}, A[HW-1:0]}) : A;
    chunk = msb ? op_q[WIDTH-1 -: CHUNK] : op_q[CHUNK-1:0];
    add = mode_q == CPOP ? CW'(pop) : found_q ? '0 : CW'(mode_q == CTZ ? tz : lz);
    acc_d = acc_q + add;
    sh = (w_q ? CW'(HW) : CW'(WIDTH)) - CW'(idx_q) * CW'(CHUNK) - CW'(CHUNK);
    macc_d = macc_q | (found_q ? '0 : WIDTH'(lzm) << sh);
    last = idx_q == (w_q ? IW'(NF / 2 - 1) : IW'(NF - 1));
    fin = last | early;
    accept = (state_q == IDLE) && (state_d == SCAN);
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else state_q <= state_d;
  end

  // Next state; Flush overrides every other transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (ReqValid) state_d = SCAN;
      SCAN: if (fin) state_d = DONE;
      DONE: if (ResReady) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (Flush) state_d = IDLE;
  end

  // Handshake outputs follow the state directly.
  always_comb begin
    ReqReady = state_q == IDLE;
    ResValid = state_q == DONE;
  end

  // Capture the request on accept, then consume one chunk per SCAN cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q <= CLZ;
      w_q <= 1'b0;
      op_q <= '0;
      idx_q <= '0;
      acc_q <= '0;
      found_q <= 1'b0;
      macc_q <= '0;
    end else if (accept) begin
      mode_q <= mode_e'(Mode);
      w_q <= W;
      op_q <= op_ld;
      idx_q <= '0;
      acc_q <= '0;
      found_q <= 1'b0;
      macc_q <= '0;
    end else if (state_q == SCAN) begin
      op_q <= msb ? op_q << CHUNK : op_q >> CHUNK;
      idx_q <= idx_q + 1'b1;
      acc_q <= acc_d;
      found_q <= found_q | ~zero;
      macc_q <= macc_d;
    end
  end

  // Results load on entry to DONE, hold while DONE persists, and read zero otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      mask_q <= '0;
    end else if (state_q == SCAN && state_d == DONE) begin
      count_q <= mode_q == LZMASK ? '0 : acc_d;
      mask_q <= mode_q == LZMASK ? macc_d : '0;
    end else if (state_d != DONE) begin
      count_q <= '0;
      mask_q <= '0;
    end
  end

  assign Count = count_q;
  assign Mask = mask_q;
endmodule

// File: doc/bitcnt_seq.md
# bitcnt_seq

Iterative, parametrised bit-counting unit for the bit-manipulation path: computes count-leading-zeros, count-trailing-zeros, population count, or a leading-zero mask of a WIDTH-bit operand. It processes CHUNK bits per cycle over a valid/ready request/response handshake. It sits beside the BMU as a multi-cycle option for area-constrained configurations, generalising the combinational leading-zero mask to multiple modes, word mode and a pipelined/iterative datapath.

## Interface
- WIDTH, 64: operand width; power of two, ≥ 2·CHUNK.
- CHUNK, 8: bits examined per cycle; power of two dividing WIDTH/2.
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- ReqValid  in  1  request present.
- ReqReady  out  1  unit can accept; high only in IDLE.
- Mode  in  2  00 CLZ, 01 CTZ, 10 CPOP, 11 LZMASK; sampled at accept.
- W  in  1  word mode; operates on A[WIDTH/2-1:0]; sampled at accept.
- A  in  WIDTH  operand; sampled at accept.
- Flush  in  1  synchronous abort; returns to IDLE next edge.
- ResValid  out  1  result available; held until taken.
- ResReady  in  1  consumer accepts result.
- Count  out  $clog2(WIDTH+1)  CLZ/CTZ/CPOP result; 0 in LZMASK mode.
- Mask  out  WIDTH  LZMASK result; 0 in other modes.

## Operation
- FSM: IDLE → SCAN on ReqValid & ReqReady; SCAN → DONE after the last chunk; DONE → IDLE on ResValid & ResReady. Flush forces IDLE from any state and overrides all other transitions.
- Effective width E = W ? WIDTH/2 : WIDTH; chunk count N = E/CHUNK. Chunk index counter 0..N-1 wraps to 0 on each accept.
- CLZ/LZMASK scan chunks from the MSB of E; CTZ scans from the LSB; CPOP in either order (LSB first).
- CLZ/CTZ: accumulate zero count until the first chunk containing a 1, then freeze. All-zero operand → Count = E.
- CPOP: sum of ones over E bits.
- LZMASK: Mask[i] = 1 iff A[E-1:i] is all zero, for i < E. Bits ≥ E are 0. All-zero operand → Mask = E ones.
- Bits of A above E are ignored in every mode.
- Count and Mask are registered. They are zero in IDLE/SCAN and stable throughout DONE.
- Reset (asynchronous, any state, including mid-scan) → IDLE, ReqReady=1, ResValid=0, Count=0, Mask=0, accumulators cleared.
- ReqValid is ignored while not in IDLE. A new request is never accepted in the same cycle a result is consumed.

## Timing
- Accept at edge k. Chunk j is processed at edge k+1+j. ResValid rises after edge k+N, so latency is N cycles.
- W=0, WIDTH=64, CHUNK=8 → 8 cycles. W=1 → 4 cycles.
- ReqReady falls the cycle after accept. It rises the cycle after the result handshake, so the minimum request-to-request spacing is N+2 cycles.
- Flush asserted in DONE discards the result: ResValid=0 next cycle.

## Configuration
- BITCNT_EARLYOUT_EN defined: in CLZ/CTZ/LZMASK, the FSM moves SCAN→DONE at the edge that processes the first chunk containing a 1. Latency is 1..N cycles; CPOP is always N.
- Undefined: every mode takes exactly N cycles. The datapath still freezes correctly after the first 1.

## Structure
- bitcnt_pkg: mode enum (CLZ, CTZ, CPOP, LZMASK), FSM state enum (IDLE, SCAN, DONE), count-width localparam function.
- One combinational sub-module, bitcnt_chunk #(CHUNK): per-chunk leading-zero count, trailing-zero count, popcount, all-zero flag and leading-zero submask.
- The top level holds the FSM, index counter, operand register, accumulators and output registers.

## Test plan
- CLZ, W=0, A=0x0000_0000_0010_0000 → Count=43 after 8 cycles (earlyout: after 6 cycles).
- CTZ, W=1, A=0xFFFF_FFFF_0000_0000 → Count=32 after 4 cycles; upper half ignored.
- CPOP, W=0, A=0xF0F0_F0F0_F0F0_F0F1 → Count=33 after 8 cycles regardless of BITCNT_EARLYOUT_EN.
- LZMASK, W=0, A=0x0000_8000_0000_0000 → Mask=0xFFFF_0000_0000_0000; A=0 → Mask all ones, Count=0.
- Backpressure: hold ResReady=0 for 5 cycles → ResValid and Count stable; ReqValid held high is not accepted until the cycle after the result handshake.
- Abort: reset_n low at scan cycle 3 → immediate IDLE with all outputs zero. Flush in DONE → ResValid=0 next cycle; a fresh request then completes correctly.
